uart_hex_loader: RTL and testbench
==================================

Name: uart_hex_loader

Overview:
Receive-side counterpart of the matrix result printer. Consumes bytes from the shared uart receiver and parses ASCII hex numbers separated by delimiters. Writes each parsed word into the sram (DATA_WIDTH 18) at consecutive addresses from BASE_ADDR. Used to load matrix operands (2 x SIZE x SIZE words) from a host terminal before the multiply FSM starts.

Parameters:
DATA_WIDTH, 18, width of the sram word and the parse accumulator
ADDR_WIDTH, 11, sram address width
BASE_ADDR, 0, address of the first word written
WORD_COUNT, 32, number of words to load before done
MAX_DIGITS, 5, maximum hex digits per word; 5 x 4 = 20 bits, truncated to DATA_WIDTH

Ports:
clk  in  1  system clock, 100 MHz
reset_n  in  1  synchronous, active-low reset
start  in  1  1-cycle pulse; begins a load, and restarts it if one is already in progress
rx_valid  in  1  1-cycle pulse from uart "received"
rx_byte  in  8  received byte, valid when rx_valid=1
rx_error  in  1  1-cycle pulse from uart recv_error
sram_we  out  1  write strobe, 1 cycle per word
sram_addr  out  ADDR_WIDTH  write address
sram_data  out  DATA_WIDTH  write data
busy  out  1  high in S_LOAD
done  out  1  high in S_DONE
words_loaded  out  $clog2(WORD_COUNT)+1  words written so far in this load
err_digits  out  1  sticky: a word had more than MAX_DIGITS digits
err_rx  out  1  sticky: rx_error seen while loading
tx_start  out  1  echo transmit pulse (see Optional Feature)
tx_data  out  8  echo byte
tx_busy  in  1  uart is_transmitting

Behaviour:
- Reset (reset_n=0 at posedge clk): state S_IDLE; all outputs 0; accumulator, digit count, word index cleared. Reset mid-load abandons the load; no further sram writes.
- States: S_IDLE -> (start) S_LOAD -> (words_loaded == WORD_COUNT) S_DONE -> (start) S_LOAD. A start pulse in S_LOAD clears word index, accumulator and sticky errors and stays in S_LOAD.
- Bytes are processed only in S_LOAD; rx_valid in S_IDLE or S_DONE is ignored.
- Hex digit ('0'-'9', 'A'-'F', 'a'-'f'): if digit count < MAX_DIGITS, acc <= {acc[DATA_WIDTH-5:0], nibble} and digit count +1. Otherwise the digit is discarded and err_digits is set.
- Delimiter (' ', ',', CR 0x0D, LF 0x0A):
  - With digit count > 0: the cycle after rx_valid, sram_we=1, sram_addr=BASE_ADDR+index, sram_data=acc. In the same update, acc, digit count and index advance and clear, so the next byte is never lost.
  - With digit count 0 (repeated delimiters): ignored.
- Any other byte ('[', ']', etc.): ignored; the partial word is kept.
- rx_error in S_LOAD: partial word discarded (acc and digit count cleared); err_rx set.
- Write latency: exactly 1 cycle from the delimiter's rx_valid to sram_we. sram_we is never high for two consecutive cycles.
- words_loaded increments in the cycle sram_we is asserted. When the WORD_COUNT-th write issues, the FSM enters S_DONE on the same edge. Any later bytes are ignored.
- Simultaneous rx_valid and start: start wins; the byte is dropped.
- sram_addr and sram_data hold their last values when sram_we=0.

Optional Feature:
Macro LOADER_ECHO_EN.
- Defined: every byte accepted in S_LOAD is echoed. tx_start pulses 1 cycle with tx_data=rx_byte, one cycle after rx_valid, provided tx_busy=0. If tx_busy=1, the echo is dropped; there is no queue.
- Undefined: tx_start and tx_data are tied 0 and the echo logic is not built.

Test Plan:
1. start, then send "1A2B3,4 " -> two writes: addr 0 = 0x1A2B3, addr 1 = 0x00004; words_loaded=2; busy=1.
2. WORD_COUNT=4, send "1 2 3 4\r\n" -> writes 1,2,3,4 to addr 0-3; done=1 after the 4th sram_we; a further "5 " produces no write.
3. Send "123456 " -> single write 0x12345; err_digits=1.
4. Send "  ,,\r\n[ab]" then " " -> no write for the delimiters; one write 0x000AB on the final space.
5. Send "12", pulse rx_error, send "7 " -> one write 0x00007; err_rx=1.
6. Mid-load: send "F " then assert reset_n=0 for 1 cycle -> all outputs 0, state S_IDLE; following "1 " without start produces no write.

Source files
------------

// File: rtl/uart_hex_loader_if.sv
// uart_hex_loader_if: groups the receive, sram-write and echo-transmit
// signals of the hex loader. The loader uses the master modport; the uart
// and sram side (or a testbench standing in for them) uses the slave modport.
interface uart_hex_loader_if #(
   parameter int DATA_WIDTH = 18,
   parameter int ADDR_WIDTH = 11
);
   logic                  rx_valid;
   logic [7:0]            rx_byte;
   logic                  rx_error;
   logic                  sram_we;
   logic [ADDR_WIDTH-1:0] sram_addr;
   logic [DATA_WIDTH-1:0] sram_data;
   logic                  tx_start;
   logic [7:0]            tx_data;
   logic                  tx_busy;

   modport master (
      input  rx_valid, rx_byte, rx_error, tx_busy,
      output sram_we, sram_addr, sram_data, tx_start, tx_data
   );

   modport slave (
      output rx_valid, rx_byte, rx_error, tx_busy,
      input  sram_we, sram_addr, sram_data, tx_start, tx_data
   );
endinterface

// File: rtl/uart_hex_loader.sv
// uart_hex_loader: parses ASCII hex words arriving from the uart receiver
// and writes each completed word into sram at BASE_ADDR + index.
// Words are delimited by space, comma, CR or LF; other non-hex bytes are
// ignored without disturbing the partial word.
// Optional macro LOADER_ECHO_EN: when defined, every byte accepted while
// loading is echoed back on tx_start/tx_data (dropped if the uart is busy).
// When undefined, tx_start/tx_data are tied low.
module uart_hex_loader #(
   parameter int DATA_WIDTH = 18,
   parameter int ADDR_WIDTH = 11,
   parameter int BASE_ADDR  = 0,
   parameter int WORD_COUNT = 32,
   parameter int MAX_DIGITS = 5,
   localparam int WL_W      = $clog2(WORD_COUNT) + 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   uart_hex_loader_if.master    bus,
   output logic                 busy,
   output logic                 done,
   output logic [WL_W-1:0]      words_loaded,
   output logic                 err_digits,
   output logic                 err_rx
);

   localparam int CNT_W = $clog2(MAX_DIGITS + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Returns {is_hex, nibble} for an ASCII byte.
   function automatic logic [4:0] hex_decode(input logic [7:0] b);
      logic [4:0] r;
      if ((b >= 8'h30) && (b <= 8'h39)) begin
         r = {1'b1, b[3:0]};
      end else if (((b >= 8'h41) && (b <= 8'h46)) || ((b >= 8'h61) && (b <= 8'h66))) begin
         r = {1'b1, b[3:0] + 4'd9};
      end else begin
         r = 5'd0;
      end
      return r;
   endfunction

   // True for the word delimiters: space, comma, CR, LF.
   function automatic logic is_delim(input logic [7:0] b);
      logic r;
      case (b)
         8'h20, 8'h2C, 8'h0D, 8'h0A: r = 1'b1;
         default:                    r = 1'b0;
      endcase
      return r;
   endfunction

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [WL_W-1:0]       words_q, words_d;
   logic                  err_digits_q, err_digits_d;
   logic                  err_rx_q, err_rx_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  sram_we_q, sram_we_d;
   logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
   logic [DATA_WIDTH-1:0] sram_data_q, sram_data_d;
   logic                  tx_start_d;
   logic [7:0]            tx_data_d;
   logic [4:0]            hex_s;
   logic                  delim_s;

   assign hex_s   = hex_decode(bus.rx_byte);
   assign delim_s = is_delim(bus.rx_byte);

   // Next-state: start restarts, rx_error drops the partial word, bytes parse in S_LOAD.
   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      words_d      = words_q;
      err_digits_d = err_digits_q;
      err_rx_d     = err_rx_q;
      sram_we_d    = 1'b0;
      sram_addr_d  = sram_addr_q;
      sram_data_d  = sram_data_q;
      tx_start_d   = 1'b0;
      tx_data_d    = 8'd0;

      if (start) begin
         state_d      = S_LOAD;
         acc_d        = {DATA_WIDTH{1'b0}};
         cnt_d        = {CNT_W{1'b0}};
         words_d      = {WL_W{1'b0}};
         err_digits_d = 1'b0;
         err_rx_d     = 1'b0;
      end else if (state_q == S_LOAD) begin
         if (bus.rx_error) begin
            acc_d    = {DATA_WIDTH{1'b0}};
            cnt_d    = {CNT_W{1'b0}};
            err_rx_d = 1'b1;
         end else if (bus.rx_valid) begin
            tx_start_d = ~bus.tx_busy;
            tx_data_d  = bus.rx_byte;
            if (hex_s[4]) begin
               if (cnt_q < CNT_W'(MAX_DIGITS)) begin
                  acc_d = {acc_q[DATA_WIDTH-5:0], hex_s[3:0]};
                  cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  err_digits_d = 1'b1;
               end
            end else if (delim_s && (cnt_q != {CNT_W{1'b0}})) begin
               sram_we_d   = 1'b1;
               sram_addr_d = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(words_q);
               sram_data_d = acc_q;
               acc_d       = {DATA_WIDTH{1'b0}};
               cnt_d       = {CNT_W{1'b0}};
               words_d     = words_q + {{(WL_W-1){1'b0}}, 1'b1};
               if ((words_q + {{(WL_W-1){1'b0}}, 1'b1}) == WL_W'(WORD_COUNT)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_LOAD;
               end
            end else begin
               // Repeated delimiters and non-hex bytes leave the partial word intact.
               acc_d = acc_q;
            end
         end else begin
            acc_d = acc_q;
         end
      end else begin
         state_d = state_q;
      end

      busy_d = (state_d == S_LOAD);
      done_d = (state_d == S_DONE);
   end

   // State and registered outputs; synchronous active-low reset clears everything.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         acc_q        <= {DATA_WIDTH{1'b0}};
         cnt_q        <= {CNT_W{1'b0}};
         words_q      <= {WL_W{1'b0}};
         err_digits_q <= 1'b0;
         err_rx_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         sram_we_q    <= 1'b0;
         sram_addr_q  <= {ADDR_WIDTH{1'b0}};
         sram_data_q  <= {DATA_WIDTH{1'b0}};
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         words_q      <= words_d;
         err_digits_q <= err_digits_d;
         err_rx_q     <= err_rx_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         sram_we_q    <= sram_we_d;
         sram_addr_q  <= sram_addr_d;
         sram_data_q  <= sram_data_d;
      end
   end

`ifdef LOADER_ECHO_EN
   logic       tx_start_q;
   logic [7:0] tx_data_q;

   // Echo register: one-cycle tx pulse carrying the accepted byte.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'd0;
      end else begin
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_start_d ? tx_data_d : tx_data_q;
      end
   end

   assign bus.tx_start = tx_start_q;
   assign bus.tx_data  = tx_data_q;
`else
   logic       unused_echo_s;
   assign unused_echo_s = bus.tx_busy ^ tx_start_d ^ (^tx_data_d);
   assign bus.tx_start  = 1'b0;
   assign bus.tx_data   = 8'd0;
`endif

   assign bus.sram_we   = sram_we_q;
   assign bus.sram_addr = sram_addr_q;
   assign bus.sram_data = sram_data_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign words_loaded  = words_q;
   assign err_digits    = err_digits_q;
   assign err_rx        = err_rx_q;

endmodule

// File: tb/tb_uart_hex_loader.sv
// tb_uart_hex_loader: directed bench for uart_hex_loader with WORD_COUNT=4.
module tb_uart_hex_loader;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic       busy;
   logic       done;
   logic [2:0] words_loaded;
   logic       err_digits;
   logic       err_rx;

   int checks = 0;
   int errors = 0;

   logic [10:0] log_addr[$];
   logic [17:0] log_data[$];
   logic        prev_we = 1'b0;
   logic        dbl_we  = 1'b0;

   logic        lat_we;
   logic [10:0] lat_addr;
   logic [17:0] lat_data;
   logic        lat_tx;
   logic [7:0]  lat_txd;

   uart_hex_loader_if #(.DATA_WIDTH(18), .ADDR_WIDTH(11)) bus ();

   uart_hex_loader #(
      .DATA_WIDTH(18), .ADDR_WIDTH(11), .BASE_ADDR(0),
      .WORD_COUNT(4),  .MAX_DIGITS(5)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .bus          (bus),
      .busy         (busy),
      .done         (done),
      .words_loaded (words_loaded),
      .err_digits   (err_digits),
      .err_rx       (err_rx)
   );

   always #5 clk = ~clk;

   // Write logger: records every sram write and flags back-to-back strobes.
   always @(negedge clk) begin
      if (bus.sram_we === 1'b1) begin
         log_addr.push_back(bus.sram_addr);
         log_data.push_back(bus.sram_data);
         if (prev_we) dbl_we = 1'b1;
      end
      prev_we = (bus.sram_we === 1'b1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      bus.rx_byte  = b;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      lat_we   = bus.sram_we;
      lat_addr = bus.sram_addr;
      lat_data = bus.sram_data;
      lat_tx   = bus.tx_start;
      lat_txd  = bus.tx_data;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      log_addr.delete();
      log_data.delete();
   endtask

   initial begin
      clk          = 1'b0;
      reset_n      = 1'b0;
      start        = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_byte  = 8'd0;
      bus.rx_error = 1'b0;
      bus.tx_busy  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_we",   {31'd0, bus.sram_we}, 32'd0);
      check("rst_words", {29'd0, words_loaded}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Idle: bytes ignored without start
      send_str("7 ");
      check("idle_nowrite", log_addr.size(), 32'd0);

      // Test 1: "1A2B3,4 "
      pulse_start();
      check("t1_busy", {31'd0, busy}, 32'd1);
      send_str("1A2B3");
      send_byte(8'h2C);
      check("t1_lat_we",   {31'd0, lat_we}, 32'd1);
      check("t1_lat_addr", {21'd0, lat_addr}, 32'd0);
      check("t1_lat_data", {14'd0, lat_data}, 32'h1A2B3);
`ifdef LOADER_ECHO_EN
      check("t1_echo",     {31'd0, lat_tx}, 32'd1);
      check("t1_echo_dat", {24'd0, lat_txd}, 32'h2C);
      bus.tx_busy = 1'b1;
      send_byte(8'h34);
      check("t1_echo_busy", {31'd0, lat_tx}, 32'd0);
      bus.tx_busy = 1'b0;
      send_byte(8'h20);
`else
      check("t1_tx_tied", {23'd0, lat_tx, lat_txd}, 32'd0);
      send_str("4 ");
`endif
      check("t1_nwrites", log_addr.size(), 32'd2);
      check("t1_w1_addr", {21'd0, log_addr[1]}, 32'd1);
      check("t1_w1_data", {14'd0, log_data[1]}, 32'h4);
      check("t1_words", {29'd0, words_loaded}, 32'd2);
      check("t1_busy2", {31'd0, busy}, 32'd1);

      // Test 2: "1 2 3 4\r\n" completes the load, then "5 " is ignored
      pulse_start();
      check("t2_words0", {29'd0, words_loaded}, 32'd0);
      send_str("1 2 3 4");
      send_byte(8'h0D);
      send_byte(8'h0A);
      check("t2_nwrites", log_addr.size(), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("t2_addr", {21'd0, log_addr[i]}, i);
         check("t2_data", {14'd0, log_data[i]}, i + 1);
      end
      check("t2_done",  {31'd0, done}, 32'd1);
      check("t2_busy",  {31'd0, busy}, 32'd0);
      check("t2_words", {29'd0, words_loaded}, 32'd4);
      send_str("5 ");
      check("t2_after_done", log_addr.size(), 32'd4);

      // Test 3: "123456 " keeps five digits and flags the overflow
      pulse_start();
      check("t3_restart_done", {31'd0, done}, 32'd0);
      send_str("123456 ");
      check("t3_nwrites", log_addr.size(), 32'd1);
      check("t3_data", {14'd0, log_data[0]}, 32'h12345);
      check("t3_err_digits", {31'd0, err_digits}, 32'd1);
      check("t3_err_rx", {31'd0, err_rx}, 32'd0);

      // start coincident with a byte: byte is dropped
      @(negedge clk);
      start        = 1'b1;
      bus.rx_valid = 1'b1;
      bus.rx_byte  = 8'h39;
      @(negedge clk);
      start        = 1'b0;
      bus.rx_valid = 1'b0;
      log_addr.delete();
      log_data.delete();
      check("t4_err_cleared", {31'd0, err_digits}, 32'd0);
      send_byte(8'h20);
      check("start_wins", log_addr.size(), 32'd0);

      // Test 4: "  ,,\r\n[ab]" then " "
      send_str("  ,,");
      send_byte(8'h0D);
      send_byte(8'h0A);
      send_str("[ab]");
      check("t4_nowrite", log_addr.size(), 32'd0);
      send_byte(8'h20);
      check("t4_nwrites", log_addr.size(), 32'd1);
      check("t4_data", {14'd0, log_data[0]}, 32'hAB);
      check("t4_addr", {21'd0, log_addr[0]}, 32'd0);

      // Test 5: "12", rx_error, "7 "
      pulse_start();
      send_str("12");
      @(negedge clk);
      bus.rx_error = 1'b1;
      @(negedge clk);
      bus.rx_error = 1'b0;
      send_str("7 ");
      check("t5_nwrites", log_addr.size(), 32'd1);
      check("t5_data", {14'd0, log_data[0]}, 32'h7);
      check("t5_err_rx", {31'd0, err_rx}, 32'd1);

      // Test 6: reset mid-load
      pulse_start();
      send_str("F ");
      check("t6_data", {14'd0, log_data[0]}, 32'hF);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check("t6_busy",  {31'd0, busy}, 32'd0);
      check("t6_done",  {31'd0, done}, 32'd0);
      check("t6_words", {29'd0, words_loaded}, 32'd0);
      check("t6_errs",  {30'd0, err_digits, err_rx}, 32'd0);
      check("t6_bus",   {bus.sram_we, bus.sram_addr, bus.sram_data}, 32'd0);
      check("t6_tx",    {23'd0, bus.tx_start, bus.tx_data}, 32'd0);
      log_addr.delete();
      log_data.delete();
      send_str("1 ");
      check("t6_nowrite", log_addr.size(), 32'd0);

      check("we_never_back_to_back", {31'd0, dbl_we}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
